// File: rtl/gs_ddram_bridge.sv
// rtl/gs_ddram_bridge.sv - GS byte-wide memory bridge onto 64-bit DDRAM with a one-line read cache
module gs_ddram_bridge #(
  parameter logic [10:0] ADDR_BASE = 11'h180
) (
  input  logic        DDRAM_CLK,
  input  logic        reset_n,
  input  logic [20:0] addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        rd,
  input  logic        we,
  output logic        ready,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [63:0] line;
  logic [17:0] tag;
  logic        valid;
  logic        wr_done;
  logic [20:0] req_addr;
  logic [7:0]  req_din;
  logic        hit;
  logic        start_wr;
  logic        start_rd;
  logic        accept;

  assign hit      = valid && (tag == addr[20:3]);
  assign start_wr = we && !wr_done;
  assign start_rd = rd && !hit;
  assign accept   = !DDRAM_BUSY;

  assign dout  = line[{addr[2:0], 3'b000} +: 8];
  assign ready = (state == IDLE) && !start_rd && !start_wr;

  // Command strobes come straight from the state register so RD and WE can never overlap.
  assign DDRAM_RD       = (state == RD_REQ);
  assign DDRAM_WE       = (state == WR_REQ);
  assign DDRAM_BURSTCNT = 8'd1;
  assign DDRAM_ADDR     = {ADDR_BASE, req_addr[20:3]};
  assign DDRAM_DIN      = {8{req_din}};
  assign DDRAM_BE       = 8'b1 << req_addr[2:0];

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_wr)      state_next = WR_REQ;
        else if (start_rd) state_next = RD_REQ;
      end
      WR_REQ:  if (accept) state_next = IDLE;
      RD_REQ:  if (accept) state_next = RD_WAIT;
      RD_WAIT: if (DDRAM_DOUT_READY) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge DDRAM_CLK) begin
    if (!reset_n) begin
      state    <= IDLE;
      line     <= 64'd0;
      tag      <= 18'd0;
      valid    <= 1'b0;
      wr_done  <= 1'b0;
      req_addr <= 21'd0;
      req_din  <= 8'd0;
    end else begin
      state <= state_next;

      if (state == IDLE) begin
        if (start_wr) begin
          req_addr <= addr;
          req_din  <= din;
        end else if (start_rd) begin
          req_addr <= addr;
        end
      end

      // Write-through: refresh the cached byte only if the line already holds this word.
      if (state == WR_REQ && accept && valid && tag == req_addr[20:3])
        line[{req_addr[2:0], 3'b000} +: 8] <= req_din;

      if (!we)
        wr_done <= 1'b0;
      else if (state == WR_REQ && accept)
        wr_done <= 1'b1;

      if (state == RD_WAIT && DDRAM_DOUT_READY) begin
        line  <= DDRAM_DOUT;
        tag   <= req_addr[20:3];
        valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gs_ddram_bridge.sv
// tb/tb_gs_ddram_bridge.sv - randomized self-checking bench for gs_ddram_bridge against a DDR memory model
module tb_gs_ddram_bridge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [20:0] addr = 21'd0;
  logic [7:0]  din = 8'd0;
  logic [7:0]  dout;
  logic        rd = 1'b0;
  logic        we = 1'b0;
  logic        ready;
  logic        DDRAM_BUSY = 1'b0;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DOUT = 64'd0;
  logic        DDRAM_DOUT_READY = 1'b0;
  logic        DDRAM_RD;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;

  always #5 clk = ~clk;

  gs_ddram_bridge #(.ADDR_BASE(11'h180)) dut (
    .DDRAM_CLK(clk), .reset_n(reset_n), .addr(addr), .din(din), .dout(dout),
    .rd(rd), .we(we), .ready(ready), .DDRAM_BUSY(DDRAM_BUSY),
    .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DOUT(DDRAM_DOUT),
    .DDRAM_DOUT_READY(DDRAM_DOUT_READY), .DDRAM_RD(DDRAM_RD), .DDRAM_DIN(DDRAM_DIN),
    .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE)
  );

  int passed = 0;
  int total  = 0;

  // DDR3 model: sparse word memory, configurable waitrequest and read latency.
  logic [63:0] mem [int];
  int          busy_cfg = 0;
  int          rd_lat_cfg = 5;
  int          busy_n = 0;
  int          rd_lat = 0;
  bit          cmd_prev = 1'b0;
  int          rd_cmds = 0;
  int          wr_cmds = 0;
  int          we_cycles = 0;
  int          both_err = 0;
  logic [28:0] last_rd_addr = 29'd0;
  logic [63:0] last_din = 64'd0;
  logic [7:0]  last_be = 8'd0;
  int          pend_word = 0;
  bit          log_q[$];

  // Expected cache contents, tracked as "which word was last filled since reset".
  bit          valid_ref = 1'b0;
  logic [17:0] tag_ref = 18'd0;

  always @(negedge clk) begin
    bit cmd;
    int w;
    cmd = DDRAM_RD || DDRAM_WE;
    if (cmd && !cmd_prev) busy_n = busy_cfg;
    cmd_prev = cmd;
    if (cmd && busy_n > 0) begin
      DDRAM_BUSY = 1'b1;
      busy_n--;
    end else begin
      DDRAM_BUSY = 1'b0;
    end
    DDRAM_DOUT_READY = 1'b0;
    if (rd_lat > 0) begin
      rd_lat--;
      if (rd_lat == 0) begin
        DDRAM_DOUT_READY = 1'b1;
        DDRAM_DOUT = mem[pend_word];
      end
    end
    if (DDRAM_WE) we_cycles++;
    if (DDRAM_RD && DDRAM_WE) both_err++;
    if (reset_n && (DDRAM_RD || DDRAM_WE) && !DDRAM_BUSY) begin
      w = int'(DDRAM_ADDR[17:0]);
      if (!mem.exists(w)) mem[w] = (w == 2) ? 64'h8877665544332211 : {$urandom, $urandom};
      if (DDRAM_RD) begin
        rd_cmds++;
        last_rd_addr = DDRAM_ADDR;
        pend_word = w;
        rd_lat = rd_lat_cfg;
        log_q.push_back(1'b0);
      end else begin
        wr_cmds++;
        last_din = DDRAM_DIN;
        last_be = DDRAM_BE;
        for (int b = 0; b < 8; b++)
          if (DDRAM_BE[b]) mem[w][8*b +: 8] = DDRAM_DIN[8*b +: 8];
        log_q.push_back(1'b1);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); #1;
    reset_n = 1'b0; rd = 1'b0; we = 1'b0; addr = 21'd0;
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    valid_ref = 1'b0;
    #1;
  endtask

  task automatic do_read(input logic [20:0] a, input int lat, input string nm);
    bit hit;
    int rc0;
    bit ok;
    logic [63:0] word_val;
    hit = valid_ref && (tag_ref == a[20:3]);
    rc0 = rd_cmds;
    rd_lat_cfg = lat;
    @(negedge clk); #1;
    addr = a; rd = 1'b1; #1;
    total++;
    if (ready !== hit) $display("FAIL %s ready_on_issue got=%0b want=%0b", nm, ready, hit);
    else passed++;
    ok = ready;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      ok = ready;
    end
    total++;
    if (!ok) $display("FAIL %s read_timeout got=ready0 want=ready1", nm);
    else passed++;
    word_val = mem.exists(int'(a[20:3])) ? mem[int'(a[20:3])] : 64'd0;
    total++;
    if (dout !== word_val[8*a[2:0] +: 8]) $display("FAIL %s dout got=%h want=%h", nm, dout, word_val[8*a[2:0] +: 8]);
    else passed++;
    total++;
    if (rd_cmds - rc0 !== (hit ? 0 : 1)) $display("FAIL %s ddr_reads got=%0d want=%0d", nm, rd_cmds - rc0, hit ? 0 : 1);
    else passed++;
    if (!hit) begin
      total++;
      if (last_rd_addr !== {11'h180, a[20:3]}) $display("FAIL %s ddram_addr got=%h want=%h", nm, last_rd_addr, {11'h180, a[20:3]});
      else passed++;
      valid_ref = 1'b1;
      tag_ref = a[20:3];
    end
    rd = 1'b0;
  endtask

  task automatic do_write(input logic [20:0] a, input logic [7:0] d, input int busy, input string nm);
    int wc0;
    int we0;
    bit ok;
    logic [7:0] exp_be;
    wc0 = wr_cmds;
    we0 = we_cycles;
    busy_cfg = busy;
    exp_be = 8'd1;
    exp_be = exp_be << a[2:0];
    @(negedge clk); #1;
    addr = a; din = d; we = 1'b1; #1;
    total++;
    if (ready !== 1'b0) $display("FAIL %s ready_on_we got=%0b want=0", nm, ready);
    else passed++;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      ok = ready;
    end
    total++;
    if (!ok) $display("FAIL %s write_timeout got=ready0 want=ready1", nm);
    else passed++;
    total++;
    if (wr_cmds - wc0 !== 1) $display("FAIL %s ddr_writes got=%0d want=1", nm, wr_cmds - wc0);
    else passed++;
    total++;
    if (we_cycles - we0 !== busy + 1) $display("FAIL %s we_cycles got=%0d want=%0d", nm, we_cycles - we0, busy + 1);
    else passed++;
    total++;
    if (last_din !== {8{d}} || last_be !== exp_be)
      $display("FAIL %s din_be got=%h/%h want=%h/%h", nm, last_din, last_be, {8{d}}, exp_be);
    else passed++;
    we = 1'b0;
    busy_cfg = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (ready !== 1'b1 || DDRAM_RD !== 1'b0 || DDRAM_WE !== 1'b0 || DDRAM_BURSTCNT !== 8'd1 || dout !== 8'd0)
      $display("FAIL reset got=rdy%0b rd%0b we%0b bc%0d dout%h want=rdy1 rd0 we0 bc1 dout00",
               ready, DDRAM_RD, DDRAM_WE, DDRAM_BURSTCNT, dout);
    else passed++;
  endtask

  task automatic test_read_miss_hit();
    do_read(21'h000013, 5, "miss_13");
    total++;
    if (dout !== 8'h44) $display("FAIL miss_13_const got=%h want=44", dout);
    else passed++;
    do_read(21'h000010, 5, "hit_10");
    total++;
    if (dout !== 8'h11) $display("FAIL hit_10_const got=%h want=11", dout);
    else passed++;
  endtask

  task automatic test_write_through();
    do_write(21'h000015, 8'hA5, 3, "write_15");
    do_read(21'h000015, 5, "hit_15");
    total++;
    if (dout !== 8'hA5) $display("FAIL hit_15_const got=%h want=a5", dout);
    else passed++;
  endtask

  task automatic test_rd_we_together();
    int rc0;
    int wc0;
    int n0;
    rc0 = rd_cmds; wc0 = wr_cmds; n0 = log_q.size();
    busy_cfg = 0; rd_lat_cfg = 3;
    @(negedge clk); #1;
    addr = 21'h000100; din = 8'h3C; rd = 1'b1; we = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    total++;
    if (wr_cmds - wc0 !== 1 || rd_cmds - rc0 !== 1)
      $display("FAIL both_counts got=w%0d r%0d want=w1 r1", wr_cmds - wc0, rd_cmds - rc0);
    else passed++;
    total++;
    if (log_q.size() < n0 + 2) $display("FAIL both_order got=%0d_cmds want=2", log_q.size() - n0);
    else if (log_q[n0] !== 1'b1 || log_q[n0+1] !== 1'b0)
      $display("FAIL both_order got=%0b%0b want=10", log_q[n0], log_q[n0+1]);
    else passed++;
    total++;
    if (ready !== 1'b1 || dout !== 8'h3C) $display("FAIL both_result got=rdy%0b %h want=rdy1 3c", ready, dout);
    else passed++;
    rd = 1'b0; we = 1'b0;
    valid_ref = 1'b1; tag_ref = 18'h20;
  endtask

  task automatic test_wrap();
    do_read(21'h1FFFFF, 2, "wrap");
    total++;
    if (last_rd_addr !== {11'h180, 18'h3FFFF}) $display("FAIL wrap_const got=%h want=%h", last_rd_addr, {11'h180, 18'h3FFFF});
    else passed++;
  endtask

  task automatic test_reset_in_rd_wait();
    int rc0;
    bit ok;
    rc0 = rd_cmds;
    rd_lat_cfg = 8;
    @(negedge clk); #1;
    addr = 21'h000040; rd = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); #1;
      ok = (rd_cmds != rc0);
    end
    total++;
    if (!ok) $display("FAIL rst_wait_issue got=no_read want=read");
    else passed++;
    @(negedge clk); #1;
    reset_n = 1'b0; rd = 1'b0;
    @(negedge clk); #1;
    reset_n = 1'b1; #1;
    valid_ref = 1'b0;
    total++;
    if (DDRAM_RD !== 1'b0 || ready !== 1'b1) $display("FAIL rst_wait_idle got=rd%0b rdy%0b want=rd0 rdy1", DDRAM_RD, ready);
    else passed++;
    for (int i = 0; i < 50 && rd_lat != 0; i++) @(negedge clk);
    #1;
    do_read(21'h000040, 3, "after_rst_miss");
  endtask

  task automatic test_random();
    logic [20:0] a;
    for (int i = 0; i < 40; i++) begin
      a = 21'($urandom_range(0, 31));
      if ($urandom_range(0, 2) == 0)
        do_write(a, 8'($urandom), $urandom_range(0, 3), "rand_wr");
      else
        do_read(a, $urandom_range(1, 6), "rand_rd");
    end
    total++;
    if (both_err !== 0) $display("FAIL rd_we_overlap got=%0d want=0", both_err);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_write_through();
    test_rd_we_together();
    test_wrap();
    test_reset_in_rd_wait();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
